// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg_if
//  Purpose  : Payload/valid/delay-slot bundle between two pipeline stages.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_dslot;
    logic              in_next_dslot;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_dslot;
    logic              next_dslot_o;

    modport master (
        output in_valid, in_data, in_dslot, in_next_dslot,
        input  out_valid, out_data, out_dslot, next_dslot_o
    );

    modport slave (
        input  in_valid, in_data, in_dslot, in_next_dslot,
        output out_valid, out_data, out_dslot, next_dslot_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Generic inter-stage pipeline register with stall, flush, bubble
//             insertion and delay-slot tracking. Optional macro PIPE_STAT_EN
//             adds saturating bubble/hold counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 DATA_W    = 32,
    parameter int                 STALL_W   = 6,
    parameter int                 STAGE     = 2,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
    input  wire                clk,
    input  wire                rst,
    input  wire [STALL_W-1:0]  stall,
    input  wire                flush,
`ifdef PIPE_STAT_EN
    output logic [15:0]        bubble_cnt,
    output logic [15:0]        hold_cnt,
`endif
    pipe_stage_reg_if.slave    bus
);

    generate
        if (STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must index inside the stall vector");
        end
    endgenerate

    logic w_up_stop;
    logic w_dn_stop;
    assign w_up_stop = stall[STAGE];
    assign w_dn_stop = stall[STAGE+1];

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_dslot;
    logic              r_next_dslot;

    // Downstream stall without upstream stall is a CTRL fault; it falls into ADVANCE.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid      <= 1'b0;
            r_data       <= NOP_VALUE;
            r_dslot      <= 1'b0;
            r_next_dslot <= 1'b0;
        end else if (!w_up_stop) begin
            r_valid <= bus.in_valid;
            r_data  <= bus.in_valid ? bus.in_data : NOP_VALUE;
            r_dslot <= bus.in_valid & bus.in_dslot;
            if (bus.in_valid) begin
                r_next_dslot <= bus.in_next_dslot;
            end
        end else if (!w_dn_stop) begin
            // Bubble: the pending delay-slot flag must survive for the next real instruction.
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
            r_dslot <= 1'b0;
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.out_data     = r_data;
    assign bus.out_dslot    = r_dslot;
    assign bus.next_dslot_o = r_next_dslot;

`ifdef PIPE_STAT_EN
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_hold_cnt;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= 16'h0000;
            r_hold_cnt   <= 16'h0000;
        end else if (!flush && w_up_stop) begin
            if (!w_dn_stop && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'h0001;
            end
            if (w_dn_stop && (r_hold_cnt != 16'hFFFF)) begin
                r_hold_cnt <= r_hold_cnt + 16'h0001;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed self-checking bench for pipe_stage_reg (STAGE=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32)) bus ();

`ifdef PIPE_STAT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] hold_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W    (32),
        .STALL_W   (6),
        .STAGE     (2),
        .NOP_VALUE (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
`ifdef PIPE_STAT_EN
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt),
`endif
        .bus        (bus.slave)
    );

    // CTRL must never stall downstream while upstream runs.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(stall[2] == 1'b0 && stall[3] == 1'b1))
                else $error("non-monotonic stall vector %b", stall);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ds, input logic nds);
        bus.in_valid      = v;
        bus.in_data       = d;
        bus.in_dslot      = ds;
        bus.in_next_dslot = nds;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 6'b000000;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_dslot", {31'b0, bus.out_dslot}, 32'd0);
        check("rst_nds", {31'b0, bus.next_dslot_o}, 32'd0);

        // Advance
        rst = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        check("adv_valid", {31'b0, bus.out_valid}, 32'd1);
        check("adv_data", bus.out_data, 32'hDEAD_BEEF);

        // Bubble
        stall = 6'b000111;
        drive(1'b1, 32'h0000_1234, 1'b0, 1'b0);
        step();
        check("bub_valid", {31'b0, bus.out_valid}, 32'd0);
        check("bub_data", bus.out_data, 32'h0);

        // Hold keeps previous output
        stall = 6'b000000;
        drive(1'b1, 32'h1111_2222, 1'b0, 1'b0);
        step();
        stall = 6'b001111;
        drive(1'b1, 32'h0000_1234, 1'b1, 1'b1);
        step();
        check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        check("hold_data", bus.out_data, 32'h1111_2222);
        check("hold_nds", {31'b0, bus.next_dslot_o}, 32'd0);

        // Delay slot across three bubbles
        stall = 6'b000000;
        drive(1'b1, 32'h0000_00B0, 1'b0, 1'b1);
        step();
        check("br_nds", {31'b0, bus.next_dslot_o}, 32'd1);
        check("br_dslot", {31'b0, bus.out_dslot}, 32'd0);
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bub3_nds", {31'b0, bus.next_dslot_o}, 32'd1);
            check("bub3_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        stall = 6'b000000;
        drive(1'b1, 32'h0000_00D5, 1'b1, 1'b0);
        step();
        check("ds_dslot", {31'b0, bus.out_dslot}, 32'd1);
        check("ds_nds", {31'b0, bus.next_dslot_o}, 32'd0);
        check("ds_data", bus.out_data, 32'h0000_00D5);

        // Invalid upstream slot keeps pending flag
        drive(1'b1, 32'h0000_00C0, 1'b0, 1'b1);
        step();
        check("inv_pre_nds", {31'b0, bus.next_dslot_o}, 32'd1);
        drive(1'b0, 32'h0000_FFFF, 1'b1, 1'b0);
        step();
        check("inv_valid", {31'b0, bus.out_valid}, 32'd0);
        check("inv_data", bus.out_data, 32'h0);
        check("inv_dslot", {31'b0, bus.out_dslot}, 32'd0);
        check("inv_nds", {31'b0, bus.next_dslot_o}, 32'd1);

        // Flush beats hold
        drive(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1);
        step();
        check("pre_fl_data", bus.out_data, 32'hA5A5_A5A5);
        stall = 6'b001111;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        check("fl_data", bus.out_data, 32'h0);
        check("fl_nds", {31'b0, bus.next_dslot_o}, 32'd0);

        // Reset during hold
        stall = 6'b000000;
        drive(1'b1, 32'h0BAD_F00D, 1'b1, 1'b1);
        step();
        stall = 6'b001111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsth_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rsth_data", bus.out_data, 32'h0);
        check("rsth_dslot", {31'b0, bus.out_dslot}, 32'd0);
        check("rsth_nds", {31'b0, bus.next_dslot_o}, 32'd0);

`ifdef PIPE_STAT_EN
        rst = 1'b1;
        stall = 6'b000000;
        step();
        rst = 1'b0;
        check("st_rst_b", {16'b0, bubble_cnt}, 32'd0);
        stall = 6'b000111;
        for (int i = 0; i < 5; i++) step();
        check("st_bub", {16'b0, bubble_cnt}, 32'd5);
        stall = 6'b001111;
        for (int i = 0; i < 70000; i++) step();
        check("st_hold", {16'b0, hold_cnt}, 32'h0000_FFFF);
        check("st_bub2", {16'b0, bubble_cnt}, 32'd5);
        stall = 6'b000000;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_fl_b", {16'b0, bubble_cnt}, 32'd5);
        check("st_fl_h", {16'b0, hold_cnt}, 32'h0000_FFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("st_clr_b", {16'b0, bubble_cnt}, 32'd0);
        check("st_clr_h", {16'b0, hold_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register that generalises the ID/EX latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus plus a valid bit.
- Honours the CTRL stall vector and a pipeline flush.
- Inserts bubbles when the upstream stage stalls and the downstream stage runs.
- Tracks the branch delay-slot flag correctly across stalls and bubbles.

Parameters:
DATA_W, 32, payload width in bits (aluop/alusel/operands/wd/wreg/link address packed by the instantiating top).
STALL_W, 6, width of the CTRL stall vector.
STAGE, 2, index of the upstream stage in the stall vector; downstream index is STAGE+1.
NOP_VALUE, 0, payload value driven on reset, flush or bubble (DATA_W bits).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall  input  STALL_W  CTRL stall vector; 1 = stop
flush  input  1  discard stage contents (exception/redirect)
in_valid  input  1  upstream payload valid
in_data  input  DATA_W  upstream payload
in_dslot  input  1  upstream instruction sits in a delay slot
in_next_dslot  input  1  upstream instruction is a branch; the next instruction is in a delay slot
out_valid  output  1  registered valid
out_data  output  DATA_W  registered payload
out_dslot  output  1  registered delay-slot flag for the downstream stage
next_dslot_o  output  1  pending delay-slot flag, fed back to the upstream decoder

Behaviour:
- Stall decode: up_stop = stall[STAGE]; dn_stop = stall[STAGE+1].
- If STAGE+1 >= STALL_W, elaboration fails (generate-time error).
- Latency: 1 clk from input to output when advancing.
- The actions below are evaluated once per posedge clk in this priority order.
- RESET (rst=1):
  - out_valid=0, out_data=NOP_VALUE, out_dslot=0, next_dslot_o=0.
- FLUSH (flush=1):
  - Same values as RESET.
  - Clears the pending delay-slot flag.
  - Flush wins over any stall combination.
- BUBBLE (up_stop=1, dn_stop=0):
  - out_valid=0, out_data=NOP_VALUE, out_dslot=0.
  - next_dslot_o holds its value, so a pending delay slot survives the bubble.
- ADVANCE (up_stop=0):
  - out_valid <= in_valid.
  - out_data <= in_valid ? in_data : NOP_VALUE.
  - out_dslot <= in_valid & in_dslot.
  - next_dslot_o <= in_valid ? in_next_dslot : next_dslot_o. An invalid upstream slot does not consume the pending flag.
- HOLD (up_stop=1, dn_stop=1):
  - All outputs hold their values.
- Stall vector not monotonic (up_stop=0, dn_stop=1): this is a CTRL error. The block still performs ADVANCE, and the bench asserts this state never occurs.
- Reset or flush mid-stall: takes effect in that same edge. The stall is ignored for that edge.
- No combinational path from inputs to outputs.

Optional Feature:
PIPE_STAT_EN
- Defined: adds outputs bubble_cnt[15:0] and hold_cnt[15:0].
  - bubble_cnt increments on each BUBBLE edge; hold_cnt increments on each HOLD edge.
  - Both saturate at 16'hFFFF.
  - Cleared by rst only; flush does not clear them.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset then advance: rst=1 for 2 cycles → out_valid=0, out_data=0, next_dslot_o=0. Then stall=0, in_valid=1, in_data=32'hDEADBEEF → out_data=32'hDEADBEEF and out_valid=1 one clk later.
- Bubble insertion (STAGE=2): stall=6'b000111 with in_data=32'h1234 → out_valid=0, out_data=NOP_VALUE. With stall=6'b001111 instead → previous output holds unchanged.
- Delay slot through a stall: advance a branch with in_next_dslot=1 → next_dslot_o=1. Apply 3 bubble cycles → next_dslot_o stays 1. Advance the next instruction with in_dslot=1, in_next_dslot=0 → out_dslot=1, next_dslot_o=0.
- Invalid upstream slot: next_dslot_o=1, advance with in_valid=0 → out_valid=0, out_data=NOP_VALUE, next_dslot_o remains 1.
- Flush priority: stall=6'b001111, flush=1, out_data=32'hA5A5A5A5 → next edge gives out_valid=0, out_data=NOP_VALUE, next_dslot_o=0.
- PIPE_STAT_EN: 5 bubble edges plus 70000 hold edges → bubble_cnt=5, hold_cnt=16'hFFFF. A flush leaves both unchanged; rst zeroes both.
